// File: rtl/capture_pkg.sv
// capture_pkg -- shared definitions for the capture controller.
//
// Contents:
//   cap_state_t     FSM state encoding, also driven out on capture_ctrl.state
//                   so the register bank can read it.
//   CTRL_START_BIT  bit position of the start control in the control register
//   CTRL_ABORT_BIT  bit position of the abort control in the control register
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } cap_state_t;

    localparam int CTRL_START_BIT = 2;
    localparam int CTRL_ABORT_BIT = 3;

endpackage

// File: rtl/capture_if.sv
// capture_if -- packet sink plus write-master bus of the capture controller.
//
// Signals:
//   st_valid/st_data/st_sop/st_eop/st_ready   Avalon-ST packet stream
//   avm_address/avm_write/avm_writedata/avm_waitrequest   Avalon-MM writes
//
// Handshake rules (both channels):
//   A stream beat transfers on a rising clk edge where st_valid && st_ready.
//   A write completes on a rising clk edge where avm_write && !avm_waitrequest;
//   while avm_waitrequest is high the master keeps address, data and
//   avm_write unchanged.
//
// Modports:
//   master  the capture controller (stream sink, memory write master)
//   slave   the environment (stream source, memory slave)
interface capture_if #(
    parameter int N = 32
) ();
    logic         st_valid;
    logic [N-1:0] st_data;
    logic         st_sop;
    logic         st_eop;
    logic         st_ready;
    logic [N-1:0] avm_address;
    logic         avm_write;
    logic [N-1:0] avm_writedata;
    logic         avm_waitrequest;

    modport master (
        input  st_valid, st_data, st_sop, st_eop, avm_waitrequest,
        output st_ready, avm_address, avm_write, avm_writedata
    );

    modport slave (
        output st_valid, st_data, st_sop, st_eop, avm_waitrequest,
        input  st_ready, avm_address, avm_write, avm_writedata
    );
endinterface

// File: rtl/capture_skid.sv
// capture_skid -- one-entry hold register between the packet stream and
// the memory write port.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_ready_en       controller allows beats to be taken this cycle
//   i_load           an accepted beat is to be written (load hold register)
//   i_data           beat data
//   i_waitrequest    memory stall
//   o_ready          st_ready: hold empty or draining this cycle
//   o_write          avm_write: hold register valid
//   o_writedata      avm_writedata: hold register contents
//   o_drain          the held word completes its write this cycle
module capture_skid #(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_ready_en,
    input  logic         i_load,
    input  logic [N-1:0] i_data,
    input  logic         i_waitrequest,
    output logic         o_ready,
    output logic         o_write,
    output logic [N-1:0] o_writedata,
    output logic         o_drain
);
    logic         r_valid;
    logic [N-1:0] r_data;

    assign o_drain     = r_valid & ~i_waitrequest;
    // A beat may enter in the same cycle the held word leaves.
    assign o_ready     = i_ready_en & (~r_valid | o_drain);
    assign o_write     = r_valid;
    assign o_writedata = r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (o_drain) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl -- captures one Avalon-ST packet into a memory window
// [cfg_begin, cfg_end) through an Avalon-MM write master.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   ctrl_start, ctrl_abort  control levels (start acts on its rising edge)
//   cfg_begin, cfg_end      word-aligned window, end exclusive
//   bus                     capture_if.master: stream sink + write master
//   state                   FSM state (IDLE/ARMED/CAPTURE/DONE)
//   words_written           completed writes since the last valid start
//   overflow                packet beats were dropped at the window end
//   cfg_err                 last start request had a bad window
//   done_irq                one-cycle pulse on entering DONE
//
// Build option: CAPTURE_WRAP_EN turns the window into a ring buffer
// (address wraps to cfg_begin, no beat is ever dropped).
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ctrl_start,
    input  logic         ctrl_abort,
    input  logic [N-1:0] cfg_begin,
    input  logic [N-1:0] cfg_end,
    capture_if.master    bus,
    output logic [1:0]   state,
    output logic [N-1:0] words_written,
    output logic         overflow,
    output logic         cfg_err,
    output logic         done_irq
);
    localparam logic [N-1:0] STEP = N'(N / 8);
    localparam logic [N-1:0] ONE  = N'(1);

    cap_state_t   r_state, w_state_nxt;
    logic         r_start_d, r_abort_pend, r_eop_seen;
    logic         r_overflow, r_cfg_err, r_done_irq;
    logic [N-1:0] r_end, r_addr, r_words;

    logic [CTRL_ABORT_BIT:CTRL_START_BIT] w_ctrl;
    logic         w_start_edge, w_start_req, w_start_ok, w_cfg_bad;
    logic         w_abort, w_active, w_ready_en, w_st_ready, w_accept;
    logic         w_avm_write, w_drain, w_hold_clear;
    logic         w_start_beat, w_cap_beat, w_load, w_discard, w_eop_now;
    logic [N-1:0] w_avm_wdata, w_addr_inc, w_addr_adv, w_slot;

    assign w_ctrl[CTRL_START_BIT] = ctrl_start;
    assign w_ctrl[CTRL_ABORT_BIT] = ctrl_abort;

    assign w_start_edge = w_ctrl[CTRL_START_BIT] & ~r_start_d;
    // Abort wins over a start seen in the same cycle.
    assign w_start_req  = ((r_state == ST_IDLE) || (r_state == ST_DONE))
                          & w_start_edge & ~w_ctrl[CTRL_ABORT_BIT];
    assign w_cfg_bad    = (cfg_begin[1:0] != 2'b00) | (cfg_end[1:0] != 2'b00)
                          | (cfg_end <= cfg_begin);
    assign w_start_ok   = w_start_req & ~w_cfg_bad;

    // An abort pulse is remembered until the presented write has finished.
    assign w_abort    = w_ctrl[CTRL_ABORT_BIT] | r_abort_pend;
    assign w_active   = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
    assign w_ready_en = w_active & ~w_abort & ~r_eop_seen;
    assign w_accept   = bus.st_valid & w_st_ready;

    assign w_addr_inc = r_addr + STEP;
`ifdef CAPTURE_WRAP_EN
    logic [N-1:0] r_begin;
    assign w_addr_adv = (w_addr_inc == r_end) ? r_begin : w_addr_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_begin <= '0;
        end else if (w_start_ok) begin
            r_begin <= cfg_begin;
        end
    end
`else
    assign w_addr_adv = w_addr_inc;
`endif

    // Address the beat accepted this cycle would be written to; it is one
    // step ahead when the held word retires in the same cycle.
    assign w_slot       = w_drain ? w_addr_adv : r_addr;
    assign w_start_beat = w_accept & (r_state == ST_ARMED) & bus.st_sop;
    assign w_cap_beat   = w_accept & (r_state == ST_CAPTURE);
    assign w_load       = w_start_beat | (w_cap_beat & (w_slot != r_end));
    assign w_discard    = w_cap_beat & (w_slot == r_end);
    assign w_eop_now    = (w_start_beat | w_cap_beat) & bus.st_eop;
    assign w_hold_clear = ~w_avm_write | w_drain;

    capture_skid #(.N(N)) u_skid (
        .i_clk         (clk),
        .i_rst_n       (reset),
        .i_ready_en    (w_ready_en),
        .i_load        (w_load),
        .i_data        (bus.st_data),
        .i_waitrequest (bus.avm_waitrequest),
        .o_ready       (w_st_ready),
        .o_write       (w_avm_write),
        .o_writedata   (w_avm_wdata),
        .o_drain       (w_drain)
    );

    assign bus.st_ready      = w_st_ready;
    assign bus.avm_write     = w_avm_write;
    assign bus.avm_writedata = w_avm_wdata;
    assign bus.avm_address   = r_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_ctrl[CTRL_ABORT_BIT]) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_start_ok) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_abort) begin
                    if (w_hold_clear) w_state_nxt = ST_IDLE;
                end else if (w_start_beat) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_abort) begin
                    if (w_hold_clear) w_state_nxt = ST_IDLE;
                end else if (r_eop_seen && w_hold_clear) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_d    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_eop_seen   <= 1'b0;
            r_overflow   <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_done_irq   <= 1'b0;
            r_end        <= '0;
            r_addr       <= '0;
            r_words      <= '0;
        end else begin
            r_start_d  <= ctrl_start;
            r_done_irq <= (r_state == ST_CAPTURE) && (w_state_nxt == ST_DONE);
            if (w_state_nxt == ST_IDLE) begin
                r_abort_pend <= 1'b0;
            end else if (w_active && ctrl_abort) begin
                r_abort_pend <= 1'b1;
            end
            if (w_start_req) begin
                if (w_cfg_bad) begin
                    r_cfg_err <= 1'b1;
                end else begin
                    r_cfg_err  <= 1'b0;
                    r_overflow <= 1'b0;
                    r_words    <= '0;
                    r_eop_seen <= 1'b0;
                    r_end      <= cfg_end;
                    r_addr     <= cfg_begin;
                end
            end else begin
                if (w_drain) begin
                    r_addr  <= w_addr_adv;
                    r_words <= r_words + ONE;
                end
                if (w_discard) r_overflow <= 1'b1;
                if (w_eop_now) r_eop_seen <= 1'b1;
            end
        end
    end

    assign state         = r_state;
    assign words_written = r_words;
    assign overflow      = r_overflow;
    assign cfg_err       = r_cfg_err;
    assign done_irq      = r_done_irq;
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl -- self-checking bench for capture_ctrl.
// The expected write list of each packet is derived from the window and
// beat index: beat k of the packet goes to begin + 4*k while it fits
// (begin + 4*(k mod slots) in the ring-buffer build), later beats are dropped.
module tb_capture_ctrl;
    localparam int N = 32;

    logic         clk;
    logic         reset;
    logic         ctrl_start;
    logic         ctrl_abort;
    logic [N-1:0] cfg_begin;
    logic [N-1:0] cfg_end;
    logic [1:0]   state;
    logic [N-1:0] words_written;
    logic         overflow;
    logic         cfg_err;
    logic         done_irq;

    capture_if #(.N(N)) bus ();

    capture_ctrl #(.N(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .ctrl_start    (ctrl_start),
        .ctrl_abort    (ctrl_abort),
        .cfg_begin     (cfg_begin),
        .cfg_end       (cfg_end),
        .bus           (bus),
        .state         (state),
        .words_written (words_written),
        .overflow      (overflow),
        .cfg_err       (cfg_err),
        .done_irq      (done_irq)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

    // memory-side model: waitrequest generation and write observation
    int   wr_mode  = 0;   // 0 none, 1 random, 2 stall write number stall_at
    int   stall_at = -1;
    bit   wr_force = 1'b0;
    int   wr_total = 0;
    int   cur_wait = 0;
    int   stall_seen = 0;
    int   stall_bad  = 0;
    int   ready_bad  = 0;
    int   irq_cnt    = 0;
    bit   wr_prev    = 1'b0;
    logic [N-1:0] held_addr, held_data;
    logic w;

    always @(negedge clk) begin
        if (wr_force)          w = 1'b1;
        else if (wr_mode == 1) w = ($urandom_range(0, 2) == 0);
        else if (wr_mode == 2) w = (wr_total == stall_at) && (cur_wait < 3);
        else                   w = 1'b0;
        bus.avm_waitrequest = w;
        #1;
        if (!reset) begin
            wr_prev  = 1'b0;
            cur_wait = 0;
        end else begin
            if (done_irq) irq_cnt++;
            if (wr_prev && (bus.avm_write !== 1'b1 || bus.avm_address !== held_addr ||
                            bus.avm_writedata !== held_data)) stall_bad++;
            if (bus.avm_write && w) begin
                if (bus.st_ready !== 1'b0) ready_bad++;
                stall_seen++;
                cur_wait++;
            end
            if (bus.avm_write && !w) begin
                got_q.push_back({bus.avm_address, bus.avm_writedata});
                wr_total++;
                cur_wait = 0;
            end
            wr_prev   = bus.avm_write && w;
            held_addr = bus.avm_address;
            held_data = bus.avm_writedata;
        end
    end

    // ---------------- checking / driver tasks ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop);
        bit ok = 1'b0;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        @(negedge clk);
        bus.st_valid = 1'b1;
        bus.st_data  = d;
        bus.st_sop   = sop;
        bus.st_eop   = eop;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (n > 0) @(negedge clk);
            #2;
            ok = bus.st_ready;
            @(posedge clk);
        end
        #1;
        bus.st_valid = 1'b0;
        bus.st_sop   = 1'b0;
        bus.st_eop   = 1'b0;
        check("beat_accepted", {63'd0, ok}, 64'd1);
    endtask

    task automatic start_cap(input logic [31:0] b, input logic [31:0] e);
        @(negedge clk);
        cfg_begin  = b;
        cfg_end    = e;
        ctrl_start = 1'b1;
        @(negedge clk);
        ctrl_start = 1'b0;
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, {62'd0, state}, {62'd0, s});
    endtask

    task automatic check_writes();
        logic [63:0] ex;
        check("write_count", 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            ex = exp_q.pop_front();
            check("write_addr_data", got_q.pop_front(), ex);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic run_packet(input logic [31:0] b, input logic [31:0] e, input int prefix,
                              input int nbeats, input int mode);
        logic [31:0] d;
        logic        sop;
        int          slots, n_exp, irq_base, stall_base, sbad_base, rbad_base;
        bit          exp_ovf;
        wr_mode    = mode;
        stall_at   = wr_total + 1;
        irq_base   = irq_cnt;
        stall_base = stall_seen;
        sbad_base  = stall_bad;
        rbad_base  = ready_bad;
        start_cap(b, e);
        check("start_state", {62'd0, state}, 64'd1);
        check("start_cfg_err", {63'd0, cfg_err}, 64'd0);
        check("start_words", {32'd0, words_written}, 64'd0);
        check("start_overflow", {63'd0, overflow}, 64'd0);
        for (int i = 0; i < prefix; i++) send_beat($urandom, 1'b0, 1'($urandom_range(0, 1)));
        slots   = int'((e - b) / 4);
        exp_ovf = 1'b0;
        n_exp   = 0;
        for (int k = 0; k < nbeats; k++) begin
            d   = $urandom;
            sop = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
`ifdef CAPTURE_WRAP_EN
            exp_q.push_back({b + 32'(4 * (k % slots)), d});
            n_exp++;
`else
            if (k < slots) begin
                exp_q.push_back({b + 32'(4 * k), d});
                n_exp++;
            end else begin
                exp_ovf = 1'b1;
            end
`endif
            send_beat(d, sop, k == nbeats - 1);
        end
        wait_state(2'b11, 200, "done_state");
        repeat (3) @(negedge clk);
        #2;
        check("words_written", {32'd0, words_written}, 64'(n_exp));
        check("overflow", {63'd0, overflow}, {63'd0, exp_ovf});
        check("done_irq_pulses", 64'(irq_cnt - irq_base), 64'd1);
        check("stall_stable", 64'(stall_bad - sbad_base), 64'd0);
        check("stall_ready_low", 64'(ready_bad - rbad_base), 64'd0);
        if (mode == 2 && n_exp >= 2) check("stall_cycles", 64'(stall_seen - stall_base), 64'd3);
        check_writes();
    endtask

    // ---------------- directed + random sequence ----------------
    logic [31:0] b, d0;
    int          irq_base0;

    initial begin
        reset = 1'b0;
        ctrl_start = 1'b0;
        ctrl_abort = 1'b0;
        cfg_begin = '0;
        cfg_end = '0;
        bus.st_valid = 1'b0;
        bus.st_data = '0;
        bus.st_sop = 1'b0;
        bus.st_eop = 1'b0;
        bus.avm_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", {62'd0, state}, 64'd0);
        check("rst_st_ready", {63'd0, bus.st_ready}, 64'd0);
        check("rst_avm_write", {63'd0, bus.avm_write}, 64'd0);
        check("rst_avm_address", {32'd0, bus.avm_address}, 64'd0);
        check("rst_words", {32'd0, words_written}, 64'd0);
        check("rst_done_irq", {63'd0, done_irq}, 64'd0);
        @(negedge clk);
        #3 reset = 1'b1;

        // bad window from IDLE: end == begin
        start_cap(32'h100, 32'h100);
        check("cfg_eq_state", {62'd0, state}, 64'd0);
        check("cfg_eq_err", {63'd0, cfg_err}, 64'd1);

        // basic 3-beat capture
        run_packet(32'h1000, 32'h1010, 0, 3, 0);
        // sop-less beats before the packet are discarded
        run_packet(32'h1000, 32'h1010, 2, 2, 0);
        // three-cycle stall on the second write
        run_packet(32'h2000, 32'h2020, 0, 4, 2);
        // window of two words, four-beat packet
        run_packet(32'h1000, 32'h1008, 0, 4, 0);
        // one-word packet (sop and eop together)
        run_packet(32'h1800, 32'h1810, 1, 1, 1);

        // bad window from DONE: misaligned begin keeps DONE
        start_cap(32'h1002, 32'h1010);
        check("cfg_mis_state", {62'd0, state}, 64'd3);
        check("cfg_mis_err", {63'd0, cfg_err}, 64'd1);

        // abort while the first write is stalled: write completes, then IDLE
        wr_mode   = 2;
        stall_at  = wr_total;
        irq_base0 = irq_cnt;
        b  = 32'h3000;
        d0 = $urandom;
        start_cap(b, 32'h3040);
        check("abort_armed", {62'd0, state}, 64'd1);
        exp_q.push_back({b, d0});
        send_beat(d0, 1'b1, 1'b0);
        @(negedge clk);
        ctrl_abort = 1'b1;
        @(negedge clk);
        ctrl_abort = 1'b0;
        #2;
        check("abort_waits_write", {62'd0, state}, 64'd2);
        wait_state(2'b00, 20, "abort_idle");
        repeat (2) @(negedge clk);
        #2;
        check("abort_no_irq", 64'(irq_cnt - irq_base0), 64'd0);
        check("abort_words", {32'd0, words_written}, 64'd1);
        check_writes();

        // abort and start in the same cycle: abort wins
        @(negedge clk);
        cfg_begin  = 32'h4000;
        cfg_end    = 32'h4010;
        ctrl_start = 1'b1;
        ctrl_abort = 1'b1;
        @(negedge clk);
        ctrl_start = 1'b0;
        ctrl_abort = 1'b0;
        #1;
        check("abort_beats_start", {62'd0, state}, 64'd0);

        // reset in the middle of a stalled write
        wr_mode  = 0;
        wr_force = 1'b1;
        start_cap(32'h5000, 32'h5010);
        send_beat($urandom, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check("pre_rst_write", {63'd0, bus.avm_write}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_state", {62'd0, state}, 64'd0);
        check("arst_avm_write", {63'd0, bus.avm_write}, 64'd0);
        check("arst_avm_address", {32'd0, bus.avm_address}, 64'd0);
        check("arst_avm_wdata", {32'd0, bus.avm_writedata}, 64'd0);
        check("arst_st_ready", {63'd0, bus.st_ready}, 64'd0);
        check("arst_words", {32'd0, words_written}, 64'd0);
        check("arst_overflow", {63'd0, overflow}, 64'd0);
        check("arst_cfg_err", {63'd0, cfg_err}, 64'd0);
        check("arst_done_irq", {63'd0, done_irq}, 64'd0);
        repeat (2) @(negedge clk);
        wr_force = 1'b0;
        @(negedge clk);
        #3 reset = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_state", {62'd0, state}, 64'd0);
        check("post_rst_write", {63'd0, bus.avm_write}, 64'd0);
        exp_q.delete();
        got_q.delete();

        // randomized windows, prefixes, packet lengths and stalls
        for (int it = 0; it < 8; it++) begin
            b = 32'h8000 + 32'($urandom_range(0, 63)) * 32'd16;
            run_packet(b, b + 32'($urandom_range(1, 5)) * 32'd4, $urandom_range(0, 2),
                       $urandom_range(1, 7), $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, meaning data/address width in bits.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports ctrl_start  in  1  (control bit 2, level) and ctrl_abort  in  1  (control bit 3, level).
REQ-005 SHALL have ports cfg_begin  in  N  (first byte address) and cfg_end  in  N  (exclusive end byte address).
REQ-006 SHALL have ports st_valid in 1, st_data in N, st_sop in 1, st_eop in 1, st_ready out 1: Avalon-ST packet sink.
REQ-007 SHALL have ports avm_address out N, avm_write out 1, avm_writedata out N, avm_waitrequest in 1: Avalon-MM write master.
REQ-008 SHALL have ports state out 2 (feeds the register bank's state input), words_written out N, overflow out 1, cfg_err out 1, done_irq out 1.

Function
REQ-009 SHALL use the state encoding IDLE=00, ARMED=01, CAPTURE=10, DONE=11, driven registered on state.
REQ-010 SHALL detect a rising edge of ctrl_start, registered one cycle; an edge seen in IDLE or DONE starts a capture.
REQ-011 SHALL, on start, check the configuration: if cfg_begin[1:0]!=0, cfg_end[1:0]!=0 or cfg_end<=cfg_begin, set cfg_err and stay in the current state.
REQ-012 SHALL, on a valid start, clear cfg_err, overflow and words_written, latch begin/end internally, load the address register with begin and enter ARMED.
REQ-013 SHALL, in ARMED, accept and discard beats without st_sop; an accepted beat with st_sop enters CAPTURE and is the first written word.
REQ-014 SHALL drive st_ready=1 in ARMED/CAPTURE when the one-entry hold register is empty or drains this cycle (avm_write && !avm_waitrequest), and 0 otherwise.
REQ-015 SHALL load each accepted CAPTURE beat into the hold register and assert avm_write with avm_address=current address while the hold register is valid.
REQ-016 SHALL hold avm_write, avm_address and avm_writedata stable while avm_waitrequest=1.
REQ-017 SHALL, on each completed write, advance the address by N/8 and increment words_written (wrapping modulo 2^N).
REQ-018 SHALL, when the next address equals the latched end, accept and discard further beats of the packet without writing them and set overflow (sticky until next valid start).
REQ-019 SHALL enter DONE once the st_eop beat has been written or discarded and the hold register is empty, and pulse done_irq high for exactly one cycle on that transition.
REQ-020 SHALL treat a beat carrying both st_sop and st_eop as a one-word packet.
REQ-021 SHALL, on ctrl_abort=1 in any state, finish any write already presented, then enter IDLE with no done_irq; abort takes priority over a simultaneous start.
REQ-022 SHALL ignore st_sop seen in CAPTURE; the beat is written as ordinary data.

Reset
REQ-023 SHALL, while reset=0, force state=IDLE, st_ready=0, avm_write=0, avm_address=0, avm_writedata=0, words_written=0, overflow=0, cfg_err=0, done_irq=0, hold register empty and edge detector cleared.
REQ-024 SHALL drop any in-flight write on reset assertion mid-capture; reset release returns cleanly to IDLE.

Configuration
REQ-025 SHALL, with CAPTURE_WRAP_EN defined, wrap the address to the latched begin instead of reaching end, write every beat as a ring buffer, and never set overflow.
REQ-026 SHALL, without CAPTURE_WRAP_EN, implement the stop-and-discard behaviour of REQ-018.

Structure
REQ-027 SHALL take the state enum, its encodings and the control bit indices (START=2, ABORT=3) from a shared package capture_pkg.
REQ-028 SHALL implement the hold register and st_ready/avm_write handshake as sub-module capture_skid; the FSM, address and counters stay in capture_ctrl.

Verification
REQ-029 SHALL cover: begin=0x1000, end=0x1010, 3-beat packet, waitrequest=0 -> writes at 0x1000/0x1004/0x1008, words_written=3, DONE, one done_irq.
REQ-030 SHALL cover: 2 beats without sop then a 2-beat sop..eop packet -> only the 2 packet words written, at begin and begin+4.
REQ-031 SHALL cover: waitrequest high 3 cycles on the second write -> address and data stable, st_ready=0 during the stall, no beat lost.
REQ-032 SHALL cover: end=begin+8, 4-beat packet -> 2 writes, overflow=1, DONE after eop; with CAPTURE_WRAP_EN -> 4 writes to begin, +4, begin, +4 and overflow=0.
REQ-033 SHALL cover: start with cfg_end=cfg_begin -> cfg_err=1, state stays IDLE; abort mid-packet -> IDLE, no done_irq.
REQ-034 SHALL cover: reset asserted mid-capture with avm_write=1 -> all outputs zero asynchronously, then IDLE after release.
